// File: rtl/mdc_pkg.sv
// Shared types and default widths for the GCD (MDC) subtract-and-compare controller.
package mdc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ITER_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ZERO,
        ERR_TIMEOUT,
        ERR_ABORT
    } err_t;

endpackage

// File: rtl/mdc_ctrl.sv
// Control FSM for the GCD datapath: drives the load/subtract/capture strobes and
// wraps the computation in a start/busy/done handshake with error reporting.
module mdc_ctrl
    import mdc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ITER_W   = DEF_ITER_W,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dtx_i,
    input  logic [DATA_W-1:0] dty_i,
    input  logic              x_d_y,
    input  logic              x_l_y,
    output logic              enb_x,
    output logic              sel_x,
    output logic              enb_y,
    output logic              sel_y,
    output logic              enb_o,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_t            state, state_n;
    err_t              code_q, code_n;
    logic [ITER_W-1:0] cnt_n;

    assign err_code = code_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_n = state;
        code_n  = code_q;
        cnt_n   = iter_cnt;
        enb_x   = 1'b0;
        sel_x   = 1'b0;
        enb_y   = 1'b0;
        sel_y   = 1'b0;
        enb_o   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_n = '0;
                    if (dtx_i != '0 && dty_i != '0) begin
                        // Operands are loaded into the datapath at the same edge that enters CALC.
                        enb_x   = 1'b1;
                        enb_y   = 1'b1;
                        code_n  = ERR_NONE;
                        state_n = CALC;
                    end else begin
                        code_n  = ERR_ZERO;
                        state_n = ERR;
                    end
                end
            end
            CALC: begin
                if (abort) begin
                    code_n  = ERR_ABORT;
                    state_n = ERR;
                end else if (!x_d_y) begin
                    enb_o   = 1'b1;
                    state_n = DONE;
                end else if (iter_cnt == ITER_LIMIT) begin
                    code_n  = ERR_TIMEOUT;
                    state_n = ERR;
                end else if (x_l_y) begin
                    enb_y = 1'b1;
                    sel_y = 1'b1;
                    cnt_n = iter_cnt + 1'b1;
                end else begin
                    enb_x = 1'b1;
                    sel_x = 1'b1;
                    cnt_n = iter_cnt + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code_q   <= ERR_NONE;
            iter_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state    <= state_n;
            code_q   <= code_n;
            iter_cnt <= cnt_n;
            busy     <= (state_n != IDLE);
            done     <= (state_n == DONE) || (state_n == ERR);
            err      <= (state_n == ERR);
        end
    end

endmodule

// File: tb/tb_mdc_ctrl.sv
// Scoreboard bench for mdc_ctrl: two instances (MAX_ITER 255 and 10) each driving a
// behavioural GCD datapath; expectations are queued at start and popped on done.
module tb_mdc_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0] start, abort, x_d_y, x_l_y;
    logic [1:0] enb_x, sel_x, enb_y, sel_y, enb_o, busy, done, err;
    logic [7:0] dtx [2];
    logic [7:0] dty [2];
    logic [1:0] err_code [2];
    logic [7:0] iter_cnt [2];
    logic [7:0] rx [2];
    logic [7:0] ry [2];
    logic [7:0] dto [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [1:0] both_seen  = 2'b00;
    logic [1:0] enbo_seen  = 2'b00;

    typedef struct {
        logic       err;
        logic [1:0] code;
        logic [7:0] iter;
        logic [7:0] dto;
        int         lat;
        int         start_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    mdc_ctrl #(.DATA_W(8), .ITER_W(8), .MAX_ITER(255)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .dtx_i(dtx[0]), .dty_i(dty[0]), .x_d_y(x_d_y[0]), .x_l_y(x_l_y[0]),
        .enb_x(enb_x[0]), .sel_x(sel_x[0]), .enb_y(enb_y[0]), .sel_y(sel_y[0]),
        .enb_o(enb_o[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .err_code(err_code[0]), .iter_cnt(iter_cnt[0])
    );

    mdc_ctrl #(.DATA_W(8), .ITER_W(8), .MAX_ITER(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .dtx_i(dtx[1]), .dty_i(dty[1]), .x_d_y(x_d_y[1]), .x_l_y(x_l_y[1]),
        .enb_x(enb_x[1]), .sel_x(sel_x[1]), .enb_y(enb_y[1]), .sel_y(sel_y[1]),
        .enb_o(enb_o[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .err_code(err_code[1]), .iter_cnt(iter_cnt[1])
    );

    // Behavioural subtract-and-compare datapath, one per controller.
    for (genvar g = 0; g < 2; g++) begin : g_dp
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rx[g]  <= '0;
                ry[g]  <= '0;
                dto[g] <= '0;
            end else begin
                if (enb_x[g]) rx[g] <= sel_x[g] ? rx[g] - ry[g] : dtx[g];
                if (enb_y[g]) ry[g] <= sel_y[g] ? ry[g] - rx[g] : dty[g];
                if (enb_o[g]) dto[g] <= rx[g];
            end
        end
        assign x_d_y[g] = (rx[g] != ry[g]);
        assign x_l_y[g] = (rx[g] <  ry[g]);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare(input int i, input exp_t e);
        check($sformatf("err[%0d]", i), 32'(err[i]), 32'(e.err));
        check($sformatf("err_code[%0d]", i), 32'(err_code[i]), 32'(e.code));
        check($sformatf("iter_cnt[%0d]", i), 32'(iter_cnt[i]), 32'(e.iter));
        check($sformatf("latency[%0d]", i), 32'(cyc - e.start_cyc), 32'(e.lat));
        if (!e.err) check($sformatf("dto[%0d]", i), 32'(dto[i]), 32'(e.dto));
    endtask

    // Monitor: pops an expectation whenever an instance presents done.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] && enb_x[i] && enb_y[i]) both_seen[i] = 1'b1;
            if (enb_o[i]) enbo_seen[i] = 1'b1;
            if (done[i] === 1'b1) begin
                if (i == 0) begin
                    if (q0.size() == 0) check("unexpected_done[0]", 32'd1, 32'd0);
                    else compare(0, q0.pop_front());
                end else begin
                    if (q1.size() == 0) check("unexpected_done[1]", 32'd1, 32'd0);
                    else compare(1, q1.pop_front());
                end
            end
        end
    end

    // mode: 0 plain, 1 abort in c3, 2 start pulse while busy in c2, 3 reset in c3 (no completion)
    task automatic run(input int i, input logic [7:0] x, input logic [7:0] y, input int mode,
                       input logic e_err, input logic [1:0] e_code, input logic [7:0] e_iter,
                       input logic [7:0] e_dto, input int e_lat);
        exp_t e;
        logic [4:0] strobes;
        int waited;
        @(negedge clk);
        dtx[i]   = x;
        dty[i]   = y;
        start[i] = 1'b1;
        e = '{err: e_err, code: e_code, iter: e_iter, dto: e_dto, lat: e_lat, start_cyc: cyc};
        if (mode != 3) begin
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
        #1;
        strobes = {enb_x[i], enb_y[i], sel_x[i], sel_y[i], enb_o[i]};
        if (x == 0 || y == 0) check("zero_start_strobes", 32'(strobes), 32'd0);
        else                  check("load_strobes", 32'(strobes), 32'b11000);
        @(negedge clk);
        start[i] = 1'b0;
        if (mode == 1) begin
            repeat (2) @(negedge clk);
            abort[i] = 1'b1;
            @(negedge clk);
            abort[i] = 1'b0;
        end else if (mode == 2) begin
            @(negedge clk);
            start[i] = 1'b1;
            dtx[i]   = 8'd5;
            dty[i]   = 8'd5;
            @(negedge clk);
            start[i] = 1'b0;
        end else if (mode == 3) begin
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
            check("rst_iter_cnt", 32'(iter_cnt[i]), 32'd0);
            check("rst_strobes", 32'({enb_x[i], enb_y[i], sel_x[i], sel_y[i], enb_o[i]}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            return;
        end
        waited = 0;
        while (((i == 0) ? q0.size() : q1.size()) != 0 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 600) begin
            check($sformatf("done_timeout[%0d]", i), 32'd1, 32'd0);
            if (i == 0) q0.delete(); else q1.delete();
        end
        repeat (3) @(negedge clk);
        check("err_code_held", 32'(err_code[i]), 32'(e_code));
        check("busy_after_done", 32'(busy[i]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        abort = '0;
        dtx[0] = '0; dty[0] = '0; dtx[1] = '0; dty[1] = '0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done_err", 32'({done, err}), 32'd0);
        check("reset_code_iter", 32'({err_code[0], err_code[1], iter_cnt[0], iter_cnt[1]}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, 8'd200, 8'd3,  3, 1'b0, 2'd0, 8'd0,   8'd0,  0);
        run(0, 8'd12,  8'd18, 0, 1'b0, 2'd0, 8'd2,   8'd6,  4);
        run(0, 8'd255, 8'd1,  0, 1'b0, 2'd0, 8'd254, 8'd1,  256);
        run(0, 8'd0,   8'd7,  0, 1'b1, 2'd1, 8'd0,   8'd0,  1);
        run(0, 8'd9,   8'd0,  0, 1'b1, 2'd1, 8'd0,   8'd0,  1);
        run(1, 8'd200, 8'd3,  0, 1'b1, 2'd2, 8'd10,  8'd0,  12);
        run(0, 8'd45,  8'd45, 0, 1'b0, 2'd0, 8'd0,   8'd45, 2);
        run(0, 8'd100, 8'd7,  1, 1'b1, 2'd3, 8'd2,   8'd0,  4);
        run(0, 8'd12,  8'd18, 2, 1'b0, 2'd0, 8'd2,   8'd6,  4);

        check("enb_x_and_enb_y_in_calc[0]", 32'(both_seen[0]), 32'd0);
        check("enb_x_and_enb_y_in_calc[1]", 32'(both_seen[1]), 32'd0);
        check("enb_o_on_timeout", 32'(enbo_seen[1]), 32'd0);
        check("pending_expectations", 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
